// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back data cache: bus widths
// and the controller state encoding.
package dcache_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_W     = 128;
  localparam int MEM_ADDR_W  = 28;
  localparam int PROC_ADDR_W = 30;
  localparam int OFFSET_W    = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty bits, tags and 4-word data blocks, one shared
// index for the read port and both write ports.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = MEM_ADDR_W - IDX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    index,
  input  logic                fill_en,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic                word_en,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag,
  output logic [BLOCK_W-1:0]  data
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_en) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_data;
    end else if (word_en) begin
      data_q[index][{word_off, 5'd0} +: WORD_W] <= word_data;
    end
  end

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache controller. Hits are
// serviced in the same cycle; misses write back a dirty victim then refill.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_read,
  input  logic                   proc_write,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic                   proc_stall,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0]     mem_wdata,
  input  logic                   mem_ready,
  input  logic [BLOCK_W-1:0]     mem_rdata
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    req_tag;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                req;
  logic                hit;
  logic                fill_en;
  logic                word_en;

  assign offset  = proc_addr[OFFSET_W-1:0];
  assign index   = proc_addr[OFFSET_W+IDX_W-1:OFFSET_W];
  assign req_tag = proc_addr[PROC_ADDR_W-1:OFFSET_W+IDX_W];

  assign req = proc_read | proc_write;
  assign hit = line_valid && (line_tag == req_tag);

  // Writes from a reset cycle are suppressed so an aborted refill never lands.
  assign fill_en = rst_n && (state == ST_ALLOCATE) && mem_ready;
  assign word_en = rst_n && (state == ST_IDLE) && proc_write && hit;

  dcache_line_array #(
    .NUM_SETS (NUM_SETS)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (index),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_data (mem_rdata),
    .word_en   (word_en),
    .word_off  (offset),
    .word_data (proc_wdata),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .data      (line_data)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req && !hit) begin
          state_nxt = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: if (mem_ready) state_nxt = ST_ALLOCATE;
      ST_ALLOCATE:  if (mem_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign proc_stall = (state != ST_IDLE) || (req && !hit);
  assign proc_rdata = line_data[{offset, 5'd0} +: WORD_W];

  assign mem_write = (state == ST_WRITEBACK);
  assign mem_read  = (state == ST_ALLOCATE);
  assign mem_addr  = (state == ST_WRITEBACK) ? {line_tag, index} : {req_tag, index};
  assign mem_wdata = line_data;

endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: a flat word-memory reference model feeds
// an expected-read queue; a behavioural memory answers block transfers.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0]  ref_mem [logic [29:0]];
  logic [127:0] bstore  [logic [27:0]];
  logic [31:0]  exp_q [$];

  int           mem_lat = 5;
  bit           spurious_ready = 0;
  bit           overlap = 0;
  int           wb_count = 0, fetch_count = 0, seq = 0, wb_seq = 0, fetch_seq = 0;
  logic [27:0]  last_wb_addr, last_fetch_addr;
  logic [127:0] last_wb_data;

  dcache_wb #(.NUM_SETS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [127:0] fetch_block(input logic [27:0] ba);
    if (bstore.exists(ba)) return bstore[ba];
    return {init_word({ba, 2'd3}), init_word({ba, 2'd2}),
            init_word({ba, 2'd1}), init_word({ba, 2'd0})};
  endfunction

  // Behavioural memory: answers after mem_lat cycles of a held request.
  initial begin
    int cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_read && mem_write) overlap = 1;
      if (mem_read || mem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          mem_ready = 1'b1;
          seq++;
          if (mem_write) begin
            bstore[mem_addr] = mem_wdata;
            wb_count++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
            wb_seq = seq;
          end else begin
            mem_rdata = fetch_block(mem_addr);
            fetch_count++;
            last_fetch_addr = mem_addr;
            fetch_seq = seq;
          end
        end
      end else begin
        cnt = 0;
        if (spurious_ready) begin
          mem_ready = 1'b1;
          mem_rdata = {4{32'hDEAD_BEEF}};
          spurious_ready = 0;
        end
      end
    end
  end

  // One processor access: drives the request, waits out the stall (bounded),
  // then checks stall length, idle memory bus and read data from the queue.
  task automatic access(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] d, input int exp_stalls, input string name);
    int stalls = 0;
    @(negedge clk);
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
    if (wr) ref_mem[a] = d;
    else if (rd) exp_q.push_back(ref_word(a));
    #1;
    while (proc_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (proc_stall) begin
      errors++;
      $display("FAIL %s stall_timeout: still stalled after %0d cycles", name, stalls);
    end
    if (exp_stalls >= 0) begin
      checks++;
      if (stalls != exp_stalls) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
      end
    end
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin
      errors++;
      $display("FAIL %s mem_idle: mem_read/mem_write=%b expected 00", name, {mem_read, mem_write});
    end
    if (rd && !wr) begin
      logic [31:0] exp = exp_q.pop_front();
      checks++;
      if (proc_rdata !== exp) begin
        errors++;
        $display("FAIL %s rdata @%h: got %h expected %h", name, a, proc_rdata, exp);
      end
    end
    @(posedge clk);
    #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({proc_stall, mem_read, mem_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: stall/rd/wr=%b expected 000", {proc_stall, mem_read, mem_write});
    end
  endtask

  task automatic test_read_miss;
    access(1, 0, 30'h10, 0, 6, "read_miss");
    checks++;
    if (last_fetch_addr !== 28'h4 || fetch_count != 1) begin
      errors++;
      $display("FAIL read_miss fetch: addr=%h count=%0d expected 0000004 / 1", last_fetch_addr, fetch_count);
    end
  endtask

  task automatic test_write_hit;
    access(0, 1, 30'h11, 32'h1234_5678, 0, "write_hit");
    access(1, 0, 30'h11, 0, 0, "read_after_write");
  endtask

  task automatic test_dirty_evict;
    int wb0 = wb_count;
    access(1, 0, 30'h30, 0, 11, "dirty_evict");
    checks++;
    if (wb_count != wb0 + 1 || last_wb_addr !== 28'h4) begin
      errors++;
      $display("FAIL dirty_evict wb: count=%0d addr=%h expected %0d / 0000004", wb_count, last_wb_addr, wb0 + 1);
    end
    checks++;
    if (last_wb_data[63:32] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL dirty_evict wdata[63:32]: got %h expected 12345678", last_wb_data[63:32]);
    end
    checks++;
    if (last_fetch_addr !== 28'hC || fetch_seq <= wb_seq) begin
      errors++;
      $display("FAIL dirty_evict refill: addr=%h order wb=%0d fetch=%0d expected 000000c after wb",
               last_fetch_addr, wb_seq, fetch_seq);
    end
  endtask

  task automatic test_clean_evict;
    int wb0 = wb_count;
    access(1, 0, 30'h10, 0, 6, "clean_evict");
    checks++;
    if (wb_count != wb0) begin
      errors++;
      $display("FAIL clean_evict no_wb: writebacks=%0d expected %0d", wb_count, wb0);
    end
    access(1, 0, 30'h11, 0, 0, "roundtrip_word");
  endtask

  task automatic test_reset_abort;
    int n = 0;
    int f0 = fetch_count;
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 30'h50;
    while (!mem_read && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    proc_read = 1'b0;
    checks++;
    if ({mem_read, mem_write} !== 2'b00 || fetch_count != f0) begin
      errors++;
      $display("FAIL reset_abort: mem_read/mem_write=%b fetches=%0d expected 00 / %0d",
               {mem_read, mem_write}, fetch_count, f0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 0, 30'h50, 0, 6, "miss_after_abort");
  endtask

  task automatic test_rw_both;
    int wb0 = wb_count;
    access(1, 1, 30'h52, 32'hA5A5_0F0F, 0, "rw_both");
    access(1, 0, 30'h72, 0, 11, "rw_both_evict");
    checks++;
    if (wb_count != wb0 + 1 || last_wb_addr !== 28'h14 || last_wb_data[95:64] !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL rw_both wb: count=%0d addr=%h word2=%h expected %0d / 0000014 / a5a50f0f",
               wb_count, last_wb_addr, last_wb_data[95:64], wb0 + 1);
    end
  endtask

  task automatic test_idle_ready;
    @(negedge clk);
    spurious_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({proc_stall, mem_read, mem_write} !== 3'b000) begin
      errors++;
      $display("FAIL idle_ready: stall/rd/wr=%b expected 000", {proc_stall, mem_read, mem_write});
    end
    access(1, 0, 30'h72, 0, 0, "idle_ready_hit");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      logic [29:0] a;
      int kind;
      mem_lat = $urandom_range(1, 4);
      a = {28'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))} ;
      kind = $urandom_range(0, 7);
      if (kind == 0)      access(1, 1, a, $urandom, -1, "b2b_rw");
      else if (kind < 4)  access(0, 1, a, $urandom, -1, "b2b_write");
      else                access(1, 0, a, 0, -1, "b2b_read");
    end
    checks++;
    if (overlap) begin
      errors++;
      $display("FAIL no_overlap: mem_read and mem_write seen together, expected never");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_dirty_evict();
    test_clean_evict();
    test_reset_abort();
    test_rw_both();
    test_idle_ready();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
